// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer for the E stage: owns HI/LO and runs multi-cycle MULT/DIV.
// Optional madd/maddu/msub/msubu accumulate ops are compiled in with `define MDU_MADD_EN.
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        req,
    output logic        start,
    output logic        busy,
    output logic [31:0] mdu_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;

    logic        is_mul;
    logic        is_div;
    logic        op_signed;
    logic        multi_cycle;
`ifdef MDU_MADD_EN
    logic        is_acc;
    logic        acc_sub;
`endif

    always_comb begin
        is_mul    = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
        is_div    = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
        op_signed = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);
`ifdef MDU_MADD_EN
        is_acc    = (mdu_op == OP_MADD) || (mdu_op == OP_MADDU) ||
                    (mdu_op == OP_MSUB) || (mdu_op == OP_MSUBU);
        acc_sub   = (mdu_op == OP_MSUB) || (mdu_op == OP_MSUBU);
        op_signed = op_signed || (mdu_op == OP_MADD) || (mdu_op == OP_MSUB);
        multi_cycle = is_mul || is_div || is_acc;
`else
        multi_cycle = is_mul || is_div;
`endif
    end

    assign start = multi_cycle && !req && !busy_q;
    assign busy  = busy_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

    always_comb begin
        mdu_out = 32'd0;
        if (mdu_op == OP_MFHI) begin
            mdu_out = hi_q;
        end else if (mdu_op == OP_MFLO) begin
            mdu_out = lo_q;
        end
    end

    // One 64x64 multiplier serves both signednesses via operand extension.
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;

    always_comb begin
        mul_a   = op_signed ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
        mul_b   = op_signed ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
        product = mul_a * mul_b;
    end

    // Signed divide via magnitudes: truncates toward zero and gives 0x80000000/-1 = 0x80000000.
    logic        div_by_zero;
    logic        num_neg;
    logic        den_neg;
    logic [31:0] num_mag;
    logic [31:0] den_mag;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quotient;
    logic [31:0] remainder;

    always_comb begin
        div_by_zero = (rt_val == 32'd0);
        num_neg     = op_signed && rs_val[31];
        den_neg     = op_signed && rt_val[31];
        num_mag     = num_neg ? (~rs_val + 32'd1) : rs_val;
        den_mag     = den_neg ? (~rt_val + 32'd1) : rt_val;
        if (div_by_zero) begin
            den_mag = 32'd1;
        end
        quo_mag   = num_mag / den_mag;
        rem_mag   = num_mag % den_mag;
        quotient  = (num_neg ^ den_neg) ? (~quo_mag + 32'd1) : quo_mag;
        remainder = num_neg ? (~rem_mag + 32'd1) : rem_mag;
    end

    logic [63:0] result;

    always_comb begin
        result = is_div ? {remainder, quotient} : product;
`ifdef MDU_MADD_EN
        if (is_acc) begin
            result = acc_sub ? ({hi_q, lo_q} - product) : ({hi_q, lo_q} + product);
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    busy_d    = 1'b1;
                    count_d   = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    pend_hi_d = result[63:32];
                    pend_lo_d = result[31:0];
                    pend_wr_d = !(is_div && div_by_zero);
                end else if (!req) begin
                    if (mdu_op == OP_MTHI) begin
                        hi_d = rs_val;
                    end
                    if (mdu_op == OP_MTLO) begin
                        lo_d = rs_val;
                    end
                end
            end
            RUN: begin
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    count_d = 4'd0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                count_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            count_q   <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer with default cycle counts (5 mult, 10 div).
module tb_mdu_sequencer;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    logic        clk;
    logic        reset;
    logic [3:0]  mdu_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        req;
    logic        start;
    logic        busy;
    logic [31:0] mdu_out;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mdu_sequencer #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .mdu_op (mdu_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .req    (req),
        .start  (start),
        .busy   (busy),
        .mdu_out(mdu_out),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    task automatic write_hl(input logic [31:0] h, input logic [31:0] l);
        mdu_op = OP_MTHI;
        rs_val = h;
        step();
        mdu_op = OP_MTLO;
        rs_val = l;
        step();
        mdu_op = OP_NONE;
        rs_val = 32'd0;
    endtask

    // Issue op in cycle T, expect busy for n cycles, then idle; optionally pulse req or
    // present a stray mult during a chosen busy cycle.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input int req_at, input int intr_at);
        mdu_op = op;
        rs_val = a;
        rt_val = b;
        req    = 1'b0;
        settle();
        check({name, " start"}, {31'd0, start}, 32'd1);
        step();
        for (int i = 1; i <= n; i++) begin
            req = (i == req_at);
            if (i == intr_at) begin
                mdu_op = OP_MULT;
                rs_val = 32'd5;
                rt_val = 32'd5;
            end else begin
                mdu_op = OP_NONE;
            end
            settle();
            check({name, " busy"}, {31'd0, busy}, 32'd1);
            if (i == intr_at) begin
                check({name, " start while busy"}, {31'd0, start}, 32'd0);
            end
            step();
        end
        req    = 1'b0;
        mdu_op = OP_NONE;
        settle();
        check({name, " done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset  = 1'b0;
        mdu_op = OP_NONE;
        rs_val = 32'd0;
        rt_val = 32'd0;
        req    = 1'b0;
        step();
        step();
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset start", {31'd0, start}, 32'd0);
        check("reset mdu_out", mdu_out, 32'd0);
        reset = 1'b1;

        run_op("mult", OP_MULT, 32'hFFFF_FFFF, 32'd2, 5, 0, 0);
        check("mult hi", hi, 32'hFFFF_FFFF);
        check("mult lo", lo, 32'hFFFF_FFFE);

        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 0, 0);
        check("multu hi", hi, 32'h0000_0001);
        check("multu lo", lo, 32'hFFFF_FFFE);

        run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, 0, 0);
        check("div lo", lo, 32'hFFFF_FFFD);
        check("div hi", hi, 32'hFFFF_FFFF);

        run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 0, 0);
        check("div ovf lo", lo, 32'h8000_0000);
        check("div ovf hi", hi, 32'h0000_0000);

        run_op("divu", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 10, 0, 0);
        check("divu lo", lo, 32'h7FFF_FFFC);
        check("divu hi", hi, 32'h0000_0001);

        write_hl(32'h11, 32'h22);
        settle();
        check("mt hi", hi, 32'h11);
        check("mt lo", lo, 32'h22);
        run_op("divu by 0", OP_DIVU, 32'd7, 32'd0, 10, 0, 0);
        check("div0 hi", hi, 32'h11);
        check("div0 lo", lo, 32'h22);

        mdu_op = OP_MTHI;
        rs_val = 32'h1234;
        settle();
        check("mthi start", {31'd0, start}, 32'd0);
        step();
        mdu_op = OP_MFLO;
        settle();
        check("mflo out", mdu_out, 32'h22);
        check("mthi hi", hi, 32'h1234);
        check("mflo busy", {31'd0, busy}, 32'd0);
        step();
        mdu_op = OP_MFHI;
        settle();
        check("mfhi out", mdu_out, 32'h1234);
        check("mfhi busy", {31'd0, busy}, 32'd0);
        step();
        mdu_op = OP_NONE;
        settle();
        check("none out", mdu_out, 32'd0);

        mdu_op = OP_MULT;
        rs_val = 32'd3;
        rt_val = 32'd4;
        req    = 1'b1;
        settle();
        check("req mult start", {31'd0, start}, 32'd0);
        step();
        mdu_op = OP_MTHI;
        rs_val = 32'hDEAD;
        req    = 1'b1;
        settle();
        check("req mult busy", {31'd0, busy}, 32'd0);
        step();
        req    = 1'b0;
        mdu_op = OP_NONE;
        settle();
        check("req mthi busy", {31'd0, busy}, 32'd0);
        check("req hi", hi, 32'h1234);
        check("req lo", lo, 32'h22);

        run_op("div req", OP_DIV, 32'd100, 32'd7, 10, 3, 0);
        check("div req lo", lo, 32'd14);
        check("div req hi", hi, 32'd2);

        mdu_op = OP_MULT;
        rs_val = 32'd3;
        rt_val = 32'd4;
        settle();
        check("rst mult start", {31'd0, start}, 32'd1);
        step();
        mdu_op = OP_NONE;
        settle();
        check("rst mult busy1", {31'd0, busy}, 32'd1);
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        settle();
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        repeat (6) step();
        check("rst no commit busy", {31'd0, busy}, 32'd0);
        check("rst no commit lo", lo, 32'd0);

        run_op("mult busy op", OP_MULT, 32'd6, 32'd7, 5, 0, 2);
        check("mult busy op lo", lo, 32'h2A);
        check("mult busy op hi", hi, 32'd0);

`ifdef MDU_MADD_EN
        write_hl(32'd0, 32'hFFFF_FFFF);
        run_op("maddu", OP_MADDU, 32'd1, 32'd1, 5, 0, 0);
        check("maddu hi", hi, 32'd1);
        check("maddu lo", lo, 32'd0);

        write_hl(32'd0, 32'd0);
        run_op("msub", OP_MSUB, 32'd1, 32'd1, 5, 0, 0);
        check("msub hi", hi, 32'hFFFF_FFFF);
        check("msub lo", lo, 32'hFFFF_FFFF);

        run_op("madd", OP_MADD, 32'hFFFF_FFFF, 32'd1, 5, 0, 0);
        check("madd hi", hi, 32'hFFFF_FFFF);
        check("madd lo", lo, 32'hFFFF_FFFE);

        run_op("msubu", OP_MSUBU, 32'hFFFF_FFFF, 32'd2, 5, 0, 0);
        check("msubu hi", hi, 32'hFFFF_FFFE);
        check("msubu lo", lo, 32'd0);
`else
        write_hl(32'h55, 32'h66);
        mdu_op = OP_MADD;
        rs_val = 32'd1;
        rt_val = 32'd1;
        settle();
        check("madd off start", {31'd0, start}, 32'd0);
        step();
        mdu_op = OP_MSUB;
        settle();
        check("madd off busy", {31'd0, busy}, 32'd0);
        check("msub off start", {31'd0, start}, 32'd0);
        step();
        mdu_op = OP_NONE;
        settle();
        check("msub off busy", {31'd0, busy}, 32'd0);
        check("madd off hi", hi, 32'h55);
        check("madd off lo", lo, 32'h66);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
